// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline sequencing controller.
//   - RV32I major opcode constants used for operand-usage decode
//   - controller state enum
//   - ctrl_t: bundle of stage enables / flushes driven by pipeline_ctrl
package pipe_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_sel;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctrl_t;

  // Field order: pc_write pc_sel if_id_write if_id_flush
  //              id_ex_write id_ex_flush ex_mem_write mem_wb_flush
  localparam ctrl_t CTRL_NORMAL   = 8'b1_0_1_0_1_0_1_0;
  localparam ctrl_t CTRL_RESET    = 8'b0_0_0_1_0_1_0_1;
  localparam ctrl_t CTRL_FAULT    = 8'b0_0_0_0_0_1_0_1;
  localparam ctrl_t CTRL_MEMSTALL = 8'b0_0_0_0_0_0_0_1;
  // IF/ID and ID/EX both squashed; EX keeps going so the branch retires.
  localparam ctrl_t CTRL_REDIRECT = 8'b1_1_1_1_1_1_1_0;
  // Hold PC and IF/ID, inject one bubble into ID/EX.
  localparam ctrl_t CTRL_LOADUSE  = 8'b0_0_0_0_1_1_1_0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   opcode, rs1, rs2 : fields of the instruction sitting in IF/ID
//   ex_memread, ex_rd: the instruction in EX is a load, and its destination
//   load_use         : IF/ID consumes a register the EX load has not produced yet
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_used, rs2_used;

  // JAL has no source registers; only R-type, branches and stores read rs2.
  assign rs1_used = (opcode != JAL);
  assign rs2_used = (opcode == OP) || (opcode == BRANCH) || (opcode == STORE);

  // x0 is hardwired zero, so a load into x0 never creates a dependency.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage RV32I pipeline.
// Resolves, in priority order, memory-wait timeout fault, MEM data-memory
// stalls, EX redirects and IF/ID load-use hazards, and drives the stage
// enables/flushes combinationally. Keeps stall/redirect performance counters.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ID_opcode, ID_rs1, ID_rs2     : IF/ID instruction fields
//   ID_EX_memread, ID_EX_rd       : load in EX and its destination
//   EX_redirect                   : taken branch / JAL resolved in EX
//   EX_MEM_memreq, MEM_ready      : MEM data access and its completion
//   pc_write .. MEM_WB_flush      : stage enables / flushes
//   mem_fault                     : sticky halt after a memory timeout
//   stall_cycles, flush_events    : performance counters (wrap, freeze in fault)
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ID_opcode,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_EX_memread,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_redirect,
  input  logic             EX_MEM_memreq,
  input  logic             MEM_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  state_e         state;
  logic [WCW-1:0] wait_cnt;
  logic           load_use, mem_stall;
  logic           act_stall, act_redirect;
  ctrl_t          ctrl;

  hazard_detect u_hazard (
    .opcode     (ID_opcode),
    .rs1        (ID_rs1),
    .rs2        (ID_rs2),
    .ex_memread (ID_EX_memread),
    .ex_rd      (ID_EX_rd),
    .load_use   (load_use)
  );

  assign mem_stall = EX_MEM_memreq && !MEM_ready;

  // Conditions actually acted on this cycle (a full freeze holds any
  // redirect/load-use; a redirect discards wrong-path load-use).
  assign act_redirect = !mem_stall && EX_redirect;
  assign act_stall    = mem_stall || (!EX_redirect && load_use);

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst)                    ctrl = CTRL_RESET;
    else if (state == FAULT)    ctrl = CTRL_FAULT;
    else if (mem_stall)         ctrl = CTRL_MEMSTALL;
    else if (EX_redirect)       ctrl = CTRL_REDIRECT;
    else if (load_use)          ctrl = CTRL_LOADUSE;
  end

  assign pc_write     = ctrl.pc_write;
  assign pc_sel       = ctrl.pc_sel;
  assign IF_ID_write  = ctrl.if_id_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_write  = ctrl.id_ex_write;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign EX_MEM_write = ctrl.ex_mem_write;
  assign MEM_WB_flush = ctrl.mem_wb_flush;

  // wait_cnt counts stall cycles so far; the timeout fires on the
  // MEM_TIMEOUT-th consecutive stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_stall) begin
          state    <= MEM_WAIT;
          wait_cnt <= WCW'(1);
        end
        MEM_WAIT: begin
          if (MEM_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (mem_stall && (wait_cnt == WCW'(MEM_TIMEOUT - 1))) begin
            state     <= FAULT;
            mem_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FAULT:   mem_fault <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state != FAULT) begin
      if (act_stall)    stall_cycles <= stall_cycles + 1'b1;
      if (act_redirect) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage RV32I pipeline. It owns the stage write-enables and bubble/flush controls around the decode stage. It resolves, in a fixed priority order, load-use hazards on the instruction in IF/ID, taken branch/jump redirects from EX, and multi-cycle data-memory waits in MEM. It also tracks memory-wait timeout (sticky fault halt) and keeps stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, number of consecutive memory-stall cycles after which the pipeline enters FAULT (≥2)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- ID_opcode  in  7  opcode field of the IF/ID instruction
- ID_rs1  in  5  rs1 of the IF/ID instruction
- ID_rs2  in  5  rs2 of the IF/ID instruction
- ID_EX_memread  in  1  instruction in EX is a load
- ID_EX_rd  in  5  destination of the instruction in EX
- EX_redirect  in  1  EX resolved a taken branch or a JAL
- EX_MEM_memreq  in  1  instruction in MEM accesses data memory
- MEM_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register enable
- pc_sel  out  1  1 = load redirect target into PC
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  IF/ID loads NOP
- ID_EX_write  out  1  ID/EX register enable
- ID_EX_flush  out  1  ID/EX loads bubble (all control bits 0)
- EX_MEM_write  out  1  EX/MEM register enable
- MEM_WB_flush  out  1  MEM/WB loads bubble
- mem_fault  out  1  sticky; pipeline halted on memory timeout
- stall_cycles  out  CNT_W  cycles with any stall asserted
- flush_events  out  CNT_W  number of redirects taken

## Operation
- State machine, registered: RUN, MEM_WAIT, FAULT. Wait counter `wait_cnt` (clog2(MEM_TIMEOUT)+1 bits).
- Operand usage from ID_opcode: rs1 used by all opcodes except JAL (1101111); rs2 used by OP (0110011), BRANCH (1100011), STORE (0100011).
- load_use = ID_EX_memread & ID_EX_rd≠0 & ((rs1 used & ID_rs1==ID_EX_rd) | (rs2 used & ID_rs2==ID_EX_rd)).
- mem_stall = EX_MEM_memreq & ~MEM_ready.
- Control outputs are combinational from state and inputs. Priority is FAULT > mem_stall > EX_redirect > load_use > normal:
  - FAULT: all write enables 0; pc_sel 0; ID_EX_flush=1, MEM_WB_flush=1.
  - mem_stall: pc_write, IF_ID_write, ID_EX_write, EX_MEM_write all 0; MEM_WB_flush=1. A pending redirect or load_use is held, not acted on.
  - redirect: pc_write=1, pc_sel=1, IF_ID_flush=1, ID_EX_flush=1. Any load_use from the wrong-path instruction is ignored.
  - load_use: pc_write=0, IF_ID_write=0, ID_EX_flush=1; the remaining enables stay 1.
  - normal: all enables 1; all flushes 0; pc_sel 0.
- State transitions:
  - RUN→MEM_WAIT on mem_stall, with wait_cnt←1.
  - MEM_WAIT with MEM_ready: →RUN, wait_cnt←0.
  - MEM_WAIT with mem_stall and wait_cnt==MEM_TIMEOUT-1: →FAULT.
  - Otherwise in MEM_WAIT: wait_cnt++.
  - FAULT is left only by rst.
- Counters wrap modulo 2^CNT_W and freeze in FAULT:
  - stall_cycles increments in any cycle where mem_stall or load_use is the acted-on condition.
  - flush_events increments in each cycle where a redirect is acted on.

## Timing
- Hazard response is zero-latency: controls apply in the same cycle the condition is visible. State and counters update on the rising clk edge.
- Load-use costs exactly 1 bubble. On the next cycle the bubble makes ID_EX_memread=0, so load_use clears without any extra state.
- Redirect costs 2 squashed instructions (IF/ID and ID/EX).
- MEM_ready in the same cycle as EX_MEM_memreq: no stall, state stays RUN.
- FAULT is entered after exactly MEM_TIMEOUT consecutive stall cycles; mem_fault goes high on the next cycle.
- Reset, including mid MEM_WAIT: while rst=1, all write enables 0, pc_sel 0, all flushes 1. On the cycle after rst deasserts: state RUN, wait_cnt 0, mem_fault 0, counters 0.

## Structure
- Shared package `pipe_pkg`: opcode constants (OP, OP_IMM, BRANCH, JAL, LOAD, STORE), the state enum, and the ctrl-bundle struct.
- Sub-module `hazard_detect`: purely combinational. Computes rs-usage and load_use from ID_opcode, ID_rs1, ID_rs2, ID_EX_memread and ID_EX_rd.
- The FSM, priority mux and counters live in pipeline_ctrl.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → exactly 1 cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles=1.
- x0 / non-user: load with rd=0 vs rs1=0, and `jal` with rs1 field=5 vs load rd=5 → no stall.
- Redirect plus load_use in the same cycle → pc_sel=1, IF_ID_flush=1, ID_EX_flush=1, no load-use stall; flush_events +1.
- Memory wait, MEM_TIMEOUT=4: MEM_ready low for 3 cycles, then high → 3 full-freeze cycles, state returns to RUN, mem_fault 0.
- Timeout, MEM_TIMEOUT=4: MEM_ready held low → 4 stall cycles, mem_fault=1 on cycle 5 and held; a redirect arriving later is ignored; counters frozen.
- Reset mid MEM_WAIT (wait_cnt=2) → next cycle RUN, counters 0, mem_fault 0.
